// File: rtl/ppu_sprite_store.sv
// Sprite slot storage and per-dot priority pixel selection for the PPU sprite pipeline.
// Optional sprite-0 hit tracking is built when PPU_SPR_ZERO_EN is defined.
module ppu_sprite_store #(
    parameter int NUM_SLOTS = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce_i,
    input  logic [7:0] store_data_i,
    input  logic [1:0] store_type_i,
    input  logic [2:0] store_index_i,
    input  logic       store_we_i,
    input  logic [3:0] valid_count_i,
    input  logic       sprite0_in_range_i,
    input  logic       shift_en_i,
    output logic [1:0] spr_pixel_o,
    output logic [1:0] spr_palette_o,
    output logic       spr_behind_bg_o,
    output logic       spr_is_zero_o
);

    localparam logic [1:0] TYPE_ATTR = 2'd0;
    localparam logic [1:0] TYPE_XPOS = 2'd1;
    localparam logic [1:0] TYPE_PLO  = 2'd2;
    localparam logic [1:0] TYPE_PHI  = 2'd3;

    logic [7:0] r_attr   [NUM_SLOTS];
    logic [7:0] r_xcnt   [NUM_SLOTS];
    logic [7:0] r_pat_lo [NUM_SLOTS];
    logic [7:0] r_pat_hi [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] w_wr_sel;
    logic [7:0]           w_pat_wdata [NUM_SLOTS];
    logic [1:0]           w_slot_pix  [NUM_SLOTS];
    logic                 w_pat_empty;
    logic                 w_win_found;
    logic                 w_win_is_slot0;

    function automatic logic [7:0] bit_reverse(input logic [7:0] d);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b] = d[7-b];
        end
        return r;
    endfunction

    // A slot beyond the evaluated sprite count is loaded transparent.
    assign w_pat_empty = ({1'b0, store_index_i} >= valid_count_i);

    // Write-select decode and per-slot pattern data (H-flip uses the stored attribute).
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_wr_sel[i] = ce_i && store_we_i && (int'(store_index_i) == i);
            if (w_pat_empty) begin
                w_pat_wdata[i] = 8'h00;
            end else if (r_attr[i][6]) begin
                w_pat_wdata[i] = bit_reverse(store_data_i);
            end else begin
                w_pat_wdata[i] = store_data_i;
            end
        end
    end

    // Attribute registers: written only, never shifted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_attr[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_wr_sel[i] && (store_type_i == TYPE_ATTR)) begin
                    r_attr[i] <= store_data_i;
                end
            end
        end
    end

    // X counters: a write overrides the decrement for the addressed slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_xcnt[i] <= 8'hFF;
            end
        end else if (ce_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_wr_sel[i] && (store_type_i == TYPE_XPOS)) begin
                    r_xcnt[i] <= store_data_i;
                end else if (shift_en_i && (r_xcnt[i] != 8'h00)) begin
                    r_xcnt[i] <= r_xcnt[i] - 8'h01;
                end
            end
        end
    end

    // Pattern shifters: shift only once the slot's counter has reached zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_pat_lo[i] <= 8'h00;
                r_pat_hi[i] <= 8'h00;
            end
        end else if (ce_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_wr_sel[i] && (store_type_i == TYPE_PLO)) begin
                    r_pat_lo[i] <= w_pat_wdata[i];
                end else if (shift_en_i && (r_xcnt[i] == 8'h00)) begin
                    r_pat_lo[i] <= {r_pat_lo[i][6:0], 1'b0};
                end
                if (w_wr_sel[i] && (store_type_i == TYPE_PHI)) begin
                    r_pat_hi[i] <= w_pat_wdata[i];
                end else if (shift_en_i && (r_xcnt[i] == 8'h00)) begin
                    r_pat_hi[i] <= {r_pat_hi[i][6:0], 1'b0};
                end
            end
        end
    end

    // Current pixel of each slot; zero until its counter expires.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_xcnt[i] == 8'h00) begin
                w_slot_pix[i] = {r_pat_hi[i][7], r_pat_lo[i][7]};
            end else begin
                w_slot_pix[i] = 2'b00;
            end
        end
    end

    // Priority select: lowest-index opaque slot drives the outputs.
    always_comb begin
        spr_pixel_o     = 2'b00;
        spr_palette_o   = 2'b00;
        spr_behind_bg_o = 1'b0;
        w_win_found     = 1'b0;
        w_win_is_slot0  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_win_found && (w_slot_pix[i] != 2'b00)) begin
                w_win_found     = 1'b1;
                w_win_is_slot0  = (i == 0);
                spr_pixel_o     = w_slot_pix[i];
                spr_palette_o   = r_attr[i][1:0];
                spr_behind_bg_o = r_attr[i][5];
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

`ifdef PPU_SPR_ZERO_EN
    logic r_sprite0;

    // Sprite-0 flag captured alongside slot 0's attribute write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sprite0 <= 1'b0;
        end else if (w_wr_sel[0] && (store_type_i == TYPE_ATTR)) begin
            r_sprite0 <= sprite0_in_range_i;
        end
    end

    assign spr_is_zero_o = r_sprite0 && w_win_is_slot0 && (spr_pixel_o != 2'b00);
`else
    logic w_unused_zero;
    assign w_unused_zero = &{1'b0, sprite0_in_range_i, w_win_is_slot0};
    assign spr_is_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_sprite_store.sv
// Randomized and directed bench for ppu_sprite_store against a slot-array reference model.
module tb_ppu_sprite_store;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ce_i;
    logic [7:0] store_data_i;
    logic [1:0] store_type_i;
    logic [2:0] store_index_i;
    logic       store_we_i;
    logic [3:0] valid_count_i;
    logic       sprite0_in_range_i;
    logic       shift_en_i;
    logic [1:0] spr_pixel_o;
    logic [1:0] spr_palette_o;
    logic       spr_behind_bg_o;
    logic       spr_is_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_attr [8];
    logic [7:0] m_x    [8];
    logic [7:0] m_lo   [8];
    logic [7:0] m_hi   [8];
    logic       m_zero;

    ppu_sprite_store #(.NUM_SLOTS(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i),
        .store_data_i(store_data_i), .store_type_i(store_type_i),
        .store_index_i(store_index_i), .store_we_i(store_we_i),
        .valid_count_i(valid_count_i), .sprite0_in_range_i(sprite0_in_range_i),
        .shift_en_i(shift_en_i), .spr_pixel_o(spr_pixel_o),
        .spr_palette_o(spr_palette_o), .spr_behind_bg_o(spr_behind_bg_o),
        .spr_is_zero_o(spr_is_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_attr[s] = 8'h00; m_x[s] = 8'hFF; m_lo[s] = 8'h00; m_hi[s] = 8'h00;
        end
        m_zero = 1'b0;
    endtask

    // Expected {pixel, palette, behind, is_zero} from the model's slot contents.
    function automatic logic [5:0] model_out();
        for (int s = 0; s < 8; s++) begin
            logic [1:0] p;
            p = (m_x[s] == 0) ? {m_hi[s][7], m_lo[s][7]} : 2'b00;
            if (p != 0) begin
                logic z;
`ifdef PPU_SPR_ZERO_EN
                z = m_zero && (s == 0);
`else
                z = 1'b0;
`endif
                return {p, m_attr[s][1:0], m_attr[s][5], z};
            end
        end
        return 6'd0;
    endfunction

    task automatic model_step(input logic ce, input logic we, input logic [1:0] ty,
                              input logic [2:0] idx, input logic [7:0] d,
                              input logic sh, input logic [3:0] vc, input logic s0);
        logic [7:0] v;
        if (!ce) return;
        for (int s = 0; s < 8; s++) begin
            logic [7:0] x0;
            x0 = m_x[s];
            if (sh) begin
                if (x0 != 0) m_x[s] = x0 - 1;
                else begin
                    m_lo[s] = m_lo[s] << 1;
                    m_hi[s] = m_hi[s] << 1;
                end
            end
        end
        if (we) begin
            if (int'(idx) >= int'(vc)) v = 8'h00;
            else if (m_attr[idx][6]) for (int b = 0; b < 8; b++) v[b] = d[7-b];
            else v = d;
            case (ty)
                2'd0: begin m_attr[idx] = d; if (idx == 0) m_zero = s0; end
                2'd1: m_x[idx] = d;
                2'd2: m_lo[idx] = v;
                default: m_hi[idx] = v;
            endcase
        end
    endtask

    // One dot: check outputs against the model, then clock and advance the model.
    task automatic cycle(input logic ce, input logic we, input logic [1:0] ty,
                         input logic [2:0] idx, input logic [7:0] d, input logic sh);
        ce_i = ce; store_we_i = we; store_type_i = ty; store_index_i = idx;
        store_data_i = d; shift_en_i = sh;
        #1;
        check("model", {spr_pixel_o, spr_palette_o, spr_behind_bg_o, spr_is_zero_o}, model_out());
        @(posedge clk_i);
        model_step(ce, we, ty, idx, d, sh, valid_count_i, sprite0_in_range_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] ty, input logic [2:0] idx, input logic [7:0] d);
        cycle(1'b1, 1'b1, ty, idx, d, 1'b0);
    endtask

    task automatic tick();
        cycle(1'b1, 1'b0, 2'd0, 3'd0, 8'h00, 1'b1);
    endtask

    task automatic clear_slots();
        for (int s = 0; s < 8; s++) begin
            wr(2'd2, 3'(s), 8'h00);
            wr(2'd3, 3'(s), 8'h00);
            wr(2'd1, 3'(s), 8'hFF);
        end
    endtask

    initial begin
        rst_i = 1'b1; ce_i = 1'b0; store_we_i = 1'b0; store_type_i = 2'd0;
        store_index_i = 3'd0; store_data_i = 8'h00; valid_count_i = 4'd0;
        sprite0_in_range_i = 1'b0; shift_en_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_out", {spr_pixel_o, spr_palette_o, spr_behind_bg_o, spr_is_zero_o}, 6'd0);
        rst_i = 1'b0;

        // Single sprite at X=3, palette 1.
        valid_count_i = 4'd1;
        wr(2'd0, 3'd0, 8'h01); wr(2'd1, 3'd0, 8'd3);
        wr(2'd2, 3'd0, 8'h80); wr(2'd3, 3'd0, 8'h00);
        for (int t = 0; t < 8; t++) begin
            #1;
            check("x3_pix", spr_pixel_o, (t == 3) ? 2'b01 : 2'b00);
            if (t == 3) check("x3_pal", spr_palette_o, 2'd1);
            tick();
        end

        // H-flip: data 01 shows on the first tick only.
        wr(2'd0, 3'd0, 8'h40); wr(2'd1, 3'd0, 8'd0);
        wr(2'd2, 3'd0, 8'h01); wr(2'd3, 3'd0, 8'h01);
        for (int t = 0; t < 8; t++) begin
            #1;
            check("flip_pix", spr_pixel_o, (t == 0) ? 2'b11 : 2'b00);
            tick();
        end

        // Priority between slots 1 and 2.
        valid_count_i = 4'd3;
        clear_slots();
        wr(2'd0, 3'd1, 8'h22); wr(2'd0, 3'd2, 8'h03);
        wr(2'd1, 3'd1, 8'd0);  wr(2'd1, 3'd2, 8'd0);
        wr(2'd2, 3'd1, 8'hFF); wr(2'd2, 3'd2, 8'hFF);
        #1;
        check("prio_pix", spr_pixel_o, 2'b01);
        check("prio_pal", spr_palette_o, 2'd2);
        check("prio_beh", spr_behind_bg_o, 1'b1);
        for (int t = 0; t < 10; t++) tick();

        // Empty line: pattern writes beyond valid_count are forced transparent.
        valid_count_i = 4'd0;
        wr(2'd0, 3'd0, 8'h00); wr(2'd1, 3'd0, 8'd0);
        wr(2'd2, 3'd0, 8'hFF); wr(2'd3, 3'd0, 8'hFF);
        for (int t = 0; t < 256; t++) begin
            if (t == 0 || t == 255) begin
                #1;
                check("empty_pix", spr_pixel_o, 2'b00);
            end
            tick();
        end

        // Sprite-0 flag.
        valid_count_i = 4'd1;
        sprite0_in_range_i = 1'b1;
        wr(2'd0, 3'd0, 8'h00); sprite0_in_range_i = 1'b0;
        wr(2'd1, 3'd0, 8'd0); wr(2'd2, 3'd0, 8'h80); wr(2'd3, 3'd0, 8'h00);
        for (int t = 0; t < 3; t++) begin
            #1;
`ifdef PPU_SPR_ZERO_EN
            check("zero_flag", spr_is_zero_o, (t == 0) ? 1'b1 : 1'b0);
`else
            check("zero_flag", spr_is_zero_o, 1'b0);
`endif
            tick();
        end

        // X=255 shows exactly one pixel on the 256th dot.
        wr(2'd0, 3'd0, 8'h02); wr(2'd1, 3'd0, 8'd255);
        wr(2'd2, 3'd0, 8'hFF); wr(2'd3, 3'd0, 8'h00);
        for (int t = 0; t < 256; t++) begin
            if (t >= 254) begin
                #1;
                check("x255_pix", spr_pixel_o, (t == 255) ? 2'b01 : 2'b00);
            end
            tick();
        end

        // Randomized traffic with lines of random sprite counts.
        for (int line = 0; line < 12; line++) begin
            valid_count_i = 4'($urandom_range(0, 8));
            for (int k = 0; k < 24; k++) begin
                cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      8'($urandom), 1'b0);
            end
            for (int k = 0; k < 160; k++) begin
                sprite0_in_range_i = 1'($urandom);
                cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
                      2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      8'($urandom), 1'($urandom));
            end
        end

        // Async reset mid-line with an opaque pixel showing.
        valid_count_i = 4'd1;
        wr(2'd0, 3'd0, 8'h03); wr(2'd1, 3'd0, 8'd0);
        wr(2'd2, 3'd0, 8'hFF); wr(2'd3, 3'd0, 8'hFF);
        #1;
        check("pre_rst_pix", spr_pixel_o, 2'b11);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_async_out", {spr_pixel_o, spr_palette_o, spr_behind_bg_o, spr_is_zero_o}, 6'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        check("rst_xcnt", dut.r_xcnt[0], 8'hFF);
        for (int t = 0; t < 4; t++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
